// File: rtl/hack_rom_loader.sv
// Boot loader: turns a length-prefixed, big-endian byte stream into one memory write per word
// and holds the CPU in reset until the image is in place. Option macro: HACK_LOADER_CHECKSUM_EN.
module hack_rom_loader #(
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_in,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_WRITE   = 4'd5,
    S_DONE    = 4'd6
`ifdef HACK_LOADER_CHECKSUM_EN
    , S_CK_HI = 4'd7,
    S_CK_LO   = 4'd8
`endif
  } state_t;

  localparam logic [31:0]       MAX_COUNT = (32'd1 << ADDR_W) - 32'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

`ifdef HACK_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CK_HI;

  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
    return acc + word;
  endfunction

  logic [15:0] sum_r;
  logic [7:0]  ck_hi_r;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t      state_r, state_s;
  logic [15:0] count_r;
  logic [15:0] index_r;
  logic [7:0]  word_hi_r;
  logic        err_s;
  logic        xfer_s;
  logic [15:0] len_s;
  logic        last_s;
  logic        byte_ready_s, mem_load_s, busy_s, done_s, cpu_reset_s;

  assign xfer_s = byte_valid && byte_ready;
  assign len_s  = {count_r[15:8], byte_data};
  assign last_s = (index_r + 16'd1) == count_r;

  // State register and registered control outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      byte_ready <= 1'b0;
      mem_load   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_reset  <= 1'b1;
    end else begin
      state_r    <= state_s;
      byte_ready <= byte_ready_s;
      mem_load   <= mem_load_s;
      busy       <= busy_s;
      done       <= done_s;
      error      <= err_s;
      cpu_reset  <= cpu_reset_s;
    end
  end

  // Next-state and next error flag
  always_comb begin
    state_s = state_r;
    err_s   = error;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s = S_LEN_HI;
          err_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      S_LEN_HI: begin
        if (xfer_s) state_s = S_LEN_LO;
        else        state_s = S_LEN_HI;
      end
      S_LEN_LO: begin
        if (!xfer_s) begin
          state_s = S_LEN_LO;
        end else if (len_s == 16'd0) begin
          state_s = END_STATE;
        end else if ({16'd0, len_s} > MAX_COUNT) begin
          // Oversize image: refuse before any write so the address never wraps
          state_s = S_DONE;
          err_s   = 1'b1;
        end else begin
          state_s = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (xfer_s) state_s = S_DATA_LO;
        else        state_s = S_DATA_HI;
      end
      S_DATA_LO: begin
        if (xfer_s) state_s = S_WRITE;
        else        state_s = S_DATA_LO;
      end
      S_WRITE: begin
        if (last_s) state_s = END_STATE;
        else        state_s = S_DATA_HI;
      end
`ifdef HACK_LOADER_CHECKSUM_EN
      S_CK_HI: begin
        if (xfer_s) state_s = S_CK_LO;
        else        state_s = S_CK_HI;
      end
      S_CK_LO: begin
        if (xfer_s) begin
          state_s = S_DONE;
          err_s   = ({ck_hi_r, byte_data} != sum_r);
        end else begin
          state_s = S_CK_LO;
        end
      end
`endif
      default: begin
        state_s = S_IDLE;
        err_s   = 1'b0;
      end
    endcase
  end

  // Output decode for the upcoming state, registered by the state register
  always_comb begin
    byte_ready_s = 1'b0;
    mem_load_s   = 1'b0;
    busy_s       = 1'b1;
    case (state_s)
      S_IDLE, S_DONE:                            busy_s       = 1'b0;
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO:  byte_ready_s = 1'b1;
`ifdef HACK_LOADER_CHECKSUM_EN
      S_CK_HI, S_CK_LO:                          byte_ready_s = 1'b1;
`endif
      S_WRITE:                                   mem_load_s   = 1'b1;
      default:                                   busy_s       = 1'b1;
    endcase
    if ((state_s == S_DONE) && !err_s) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
    cpu_reset_s = !done_s;
  end

  // Datapath: length, word assembly, write port, index and checksum
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r     <= 16'd0;
      index_r     <= 16'd0;
      word_hi_r   <= 8'd0;
      mem_address <= BASE;
      mem_in      <= 16'd0;
`ifdef HACK_LOADER_CHECKSUM_EN
      sum_r       <= 16'd0;
      ck_hi_r     <= 8'd0;
`endif
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            index_r <= 16'd0;
`ifdef HACK_LOADER_CHECKSUM_EN
            sum_r   <= 16'd0;
`endif
          end
        end
        S_LEN_HI:  if (xfer_s) count_r[15:8] <= byte_data;
        S_LEN_LO:  if (xfer_s) count_r[7:0]  <= byte_data;
        S_DATA_HI: if (xfer_s) word_hi_r     <= byte_data;
        S_DATA_LO: begin
          if (xfer_s) begin
            mem_address <= BASE + ADDR_W'(index_r);
            mem_in      <= {word_hi_r, byte_data};
          end
        end
        S_WRITE: begin
          index_r <= index_r + 16'd1;
`ifdef HACK_LOADER_CHECKSUM_EN
          sum_r   <= csum_add(sum_r, mem_in);
`endif
        end
`ifdef HACK_LOADER_CHECKSUM_EN
        S_CK_HI:   if (xfer_s) ck_hi_r <= byte_data;
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Self-checking bench for hack_rom_loader: two instances (ADDR_W=15 and ADDR_W=4), table vectors,
// hand sequences and random loads compared against a stream-level reference model.
`timescale 1ns/1ps
module tb_hack_rom_loader;
`ifdef HACK_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int AW0 = 15, AW1 = 4, B0 = 0, B1 = 0;

  typedef struct {
    int          inst;
    int          count;
    int          gaps;
    logic [15:0] seed;
    bit          ckbad;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n [2];
  logic           start_v [2];
  logic           bv [2];
  logic [7:0]     bd [2];
  logic           br [2], ml [2], cr [2], bz [2], dn [2], er [2];
  logic [15:0]    min_v [2];
  logic [AW0-1:0] addr0;
  logic [AW1-1:0] addr1;
  logic [15:0]    addr_n [2];
  assign addr_n[0] = 16'(addr0);
  assign addr_n[1] = 16'(addr1);

  hack_rom_loader #(.ADDR_W(AW0), .BASE_ADDR(B0)) dut0 (
    .clk(clk), .reset_n(reset_n[0]), .start(start_v[0]), .byte_valid(bv[0]), .byte_data(bd[0]),
    .byte_ready(br[0]), .mem_load(ml[0]), .mem_address(addr0), .mem_in(min_v[0]),
    .cpu_reset(cr[0]), .busy(bz[0]), .done(dn[0]), .error(er[0]));

  hack_rom_loader #(.ADDR_W(AW1), .BASE_ADDR(B1)) dut1 (
    .clk(clk), .reset_n(reset_n[1]), .start(start_v[1]), .byte_valid(bv[1]), .byte_data(bd[1]),
    .byte_ready(br[1]), .mem_load(ml[1]), .mem_address(addr1), .mem_in(min_v[1]),
    .cpu_reset(cr[1]), .busy(bz[1]), .done(dn[1]), .error(er[1]));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] obs0[$], obs1[$];
  logic [31:0] ew[$];
  bit          edone, eerr;
  logic [7:0]  sb[$];
  logic        prev_ml [2];

  // Write monitor: records every write and checks the write cycle is isolated and not accepting bytes
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ml[i] === 1'b1) begin
        checks++;
        if (br[i] !== 1'b0 || prev_ml[i] === 1'b1) begin
          errors++;
          $display("FAIL write_cycle inst%0d: byte_ready=%b prev_load=%b, required 0 and 0", i, br[i], prev_ml[i]);
        end
        if (i == 0) obs0.push_back({addr_n[0], min_v[0]});
        else        obs1.push_back({addr_n[1], min_v[1]});
      end
      prev_ml[i] = ml[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic int max_count(input int k);
    return (k == 0) ? ((1 << AW0) - B0) : ((1 << AW1) - B1);
  endfunction

  // Reference: interpret the stream by its rules, yielding writes and final flags
  task automatic model(input int k, input logic [7:0] b[$]);
    int          cnt;
    logic [15:0] sum, w;
    ew.delete();
    sum  = 16'd0;
    eerr = 1'b0;
    cnt  = int'({b[0], b[1]});
    if (cnt > max_count(k)) begin
      eerr = 1'b1;
    end else begin
      for (int i = 0; i < cnt; i++) begin
        w   = {b[2+2*i], b[3+2*i]};
        sum = sum + w;
        ew.push_back({16'((k == 0 ? B0 : B1) + i), w});
      end
      if (CK && (sum != {b[2+2*cnt], b[3+2*cnt]})) eerr = 1'b1;
    end
    edone = !eerr;
  endtask

  task automatic build(input int k, input int cnt, input logic [15:0] seed, input bit ckbad);
    logic [15:0] sum, w;
    sb.delete();
    sum = 16'd0;
    sb.push_back(8'(cnt >> 8));
    sb.push_back(8'(cnt));
    if (cnt <= max_count(k)) begin
      for (int i = 0; i < cnt; i++) begin
        w   = seed + 16'(i) * 16'h9E37;
        sum = sum + w;
        sb.push_back(w[15:8]);
        sb.push_back(w[7:0]);
      end
      if (CK) begin
        sum = sum + 16'(ckbad);
        sb.push_back(sum[15:8]);
        sb.push_back(sum[7:0]);
      end
    end
  endtask

  task automatic append_ck();
    logic [15:0] sum;
    sum = 16'd0;
    for (int i = 2; i + 1 < sb.size(); i += 2) sum = sum + {sb[i], sb[i+1]};
    if (CK) begin
      sb.push_back(sum[15:8]);
      sb.push_back(sum[7:0]);
    end
  endtask

  task automatic start_pulse(input int k);
    @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  // gaps: 0 = continuous, 1 = random gaps and stray start pulses, 2 = valid every other cycle
  task automatic send_bytes(input int k, input logic [7:0] b[$], input int gaps);
    int i, n;
    bit ph;
    i = 0; n = 0; ph = 1'b0;
    while (i < b.size() && n < 5000) begin
      @(negedge clk);
      n++;
      ph = !ph;
      start_v[k] = (gaps == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if ((gaps == 1 && $urandom_range(0, 2) == 0) || (gaps == 2 && ph)) begin
        bv[k] = 1'b0;
        bd[k] = 8'($urandom);
      end else begin
        bv[k] = 1'b1;
        bd[k] = b[i];
        if (br[k] === 1'b1) i++;
      end
    end
    chk("stream_accepted", 32'(i), 32'(b.size()));
    @(negedge clk);
    bv[k] = 1'b0;
    start_v[k] = 1'b0;
    bd[k] = 8'h00;
  endtask

  task automatic run_load(input int k, input logic [7:0] b[$], input int gaps);
    int waited, nw;
    model(k, b);
    if (k == 0) obs0.delete(); else obs1.delete();
    start_pulse(k);
    send_bytes(k, b, gaps);
    waited = 0;
    while (bz[k] !== 1'b0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("done_latency", 32'(waited), (!CK && ew.size() > 0) ? 32'd1 : 32'd0);
    chk("done", 32'(dn[k]), 32'(edone));
    chk("error", 32'(er[k]), 32'(eerr));
    chk("cpu_reset", 32'(cr[k]), 32'(!edone));
    nw = (k == 0) ? obs0.size() : obs1.size();
    chk("write_count", 32'(nw), 32'(ew.size()));
    for (int i = 0; i < ew.size() && i < nw; i++)
      chk("write_addr_data", (k == 0) ? obs0[i] : obs1[i], ew[i]);
    if (ew.size() > 0) chk("hold_addr_data", {addr_n[k], min_v[k]}, ew[ew.size()-1]);
  endtask

  task automatic check_reset(input int k);
    chk("rst_byte_ready", 32'(br[k]), 32'd0);
    chk("rst_mem_load", 32'(ml[k]), 32'd0);
    chk("rst_mem_address", 32'(addr_n[k]), 32'(k == 0 ? B0 : B1));
    chk("rst_mem_in", 32'(min_v[k]), 32'd0);
    chk("rst_cpu_reset", 32'(cr[k]), 32'd1);
    chk("rst_busy", 32'(bz[k]), 32'd0);
    chk("rst_done", 32'(dn[k]), 32'd0);
    chk("rst_error", 32'(er[k]), 32'd0);
  endtask

  initial begin
    vec_t tbl[$];
    int   k, cnt;
    tbl.push_back('{0, 3,     0, 16'h1111, 1'b0, 1'b1, 1'b0, 3});
    tbl.push_back('{0, 0,     0, 16'h0000, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{1, 17,    0, 16'h0000, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1, 16,    1, 16'hF00D, 1'b0, 1'b1, 1'b0, 16});
    tbl.push_back('{1, 1,     2, 16'h8000, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{0, 32769, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{0, 12,    1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 12});
    tbl.push_back('{1, 65535, 2, 16'h0000, 1'b0, 1'b0, 1'b1, 0});
    if (CK) begin
      tbl.push_back('{0, 4, 0, 16'hC000, 1'b1, 1'b0, 1'b1, 4});
      tbl.push_back('{1, 0, 1, 16'h0000, 1'b1, 1'b0, 1'b1, 0});
    end

    for (int i = 0; i < 2; i++) begin
      reset_n[i] = 1'b0; start_v[i] = 1'b0; bv[i] = 1'b0; bd[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;

    // Basic three-word image, then the same with valid toggling every other cycle
    sb = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};
    append_ck();
    for (int g = 0; g < 3; g += 2) begin
      run_load(0, sb, g);
      chk("plan_w0", obs0.size() > 0 ? obs0[0] : 32'hX, 32'h0000_1234);
      chk("plan_w1", obs0.size() > 1 ? obs0[1] : 32'hX, 32'h0001_ABCD);
      chk("plan_w2", obs0.size() > 2 ? obs0[2] : 32'hX, 32'h0002_0007);
      chk("plan_done", 32'(dn[0]), 32'd1);
      chk("plan_cpu_reset", 32'(cr[0]), 32'd0);
    end

    for (int t = 0; t < tbl.size(); t++) begin
      k = tbl[t].inst;
      build(k, tbl[t].count, tbl[t].seed, tbl[t].ckbad);
      run_load(k, sb, tbl[t].gaps);
      chk("tbl_done", 32'(dn[k]), 32'(tbl[t].exp_done));
      chk("tbl_error", 32'(er[k]), 32'(tbl[t].exp_err));
      chk("tbl_writes", 32'(k == 0 ? obs0.size() : obs1.size()), 32'(tbl[t].exp_writes));
    end

    // Small memory: oversize refused, then a one-word image loads from address 0
    sb = '{8'h00, 8'h11};
    run_load(1, sb, 0);
    chk("small_err", 32'(er[1]), 32'd1);
    chk("small_done", 32'(dn[1]), 32'd0);
    chk("small_cpu_reset", 32'(cr[1]), 32'd1);
    sb = '{8'h00, 8'h01, 8'h55, 8'hAA};
    append_ck();
    run_load(1, sb, 0);
    chk("small_w0", obs1.size() > 0 ? obs1[0] : 32'hX, 32'h0000_55AA);
    chk("small_done2", 32'(dn[1]), 32'd1);

    // Reset pulse right after the second word's write
    sb = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    obs0.delete();
    start_pulse(0);
    send_bytes(0, sb, 0);
    chk("pre_reset_load", 32'(ml[0]), 32'd1);
    reset_n[0] = 1'b0;
    @(negedge clk);
    reset_n[0] = 1'b1;
    check_reset(0);
    chk("pre_reset_writes", 32'(obs0.size()), 32'd2);
    sb = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    append_ck();
    run_load(0, sb, 0);
    chk("restart_w0", obs0.size() > 0 ? obs0[0] : 32'hX, 32'h0000_BEEF);

    if (CK) begin
      sb = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
      run_load(0, sb, 0);
      chk("ck_good_done", 32'(dn[0]), 32'd1);
      sb = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04};
      run_load(0, sb, 0);
      chk("ck_bad_err", 32'(er[0]), 32'd1);
      chk("ck_bad_cpu_reset", 32'(cr[0]), 32'd1);
    end

    // Random images across both instances
    for (int r = 0; r < 30; r++) begin
      k   = $urandom_range(0, 1);
      cnt = (k == 1) ? $urandom_range(0, 18) : $urandom_range(0, 10);
      if ($urandom_range(0, 7) == 0) cnt = $urandom_range(32769, 65535);
      build(k, cnt, 16'($urandom), CK && ($urandom_range(0, 3) == 0));
      run_load(k, sb, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
